// File: rtl/row_multiply_sequencer_if.sv
// Bus bundle between the row-multiply sequencer and its environment:
// top-level control, row-wide memory and the element-wise multiplicator.
interface row_multiply_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // top-level control
  logic                  Start;
  logic [2:0]            Operation;
  logic [ADDR_W-1:0]     BaseA;
  logic [ADDR_W-1:0]     BaseB;
  logic [ADDR_W-1:0]     BaseC;
  logic                  Busy;
  logic                  Done;
  logic                  Error;
  // row-wide memory
  logic [ADDR_W-1:0]     MemAddr;
  logic                  MemRead;
  logic                  MemWrite;
  logic [4*DATA_W-1:0]   MemDataOut;
  logic [4*DATA_W-1:0]   MemDataIn;
  // multiplicator
  logic [2:0]            MulOperation;
  logic                  MulEnable;
  logic [4*DATA_W-1:0]   MulRowA;
  logic [4*DATA_W-1:0]   MulRowB;
  logic [4*DATA_W-1:0]   MulNewRow;
  logic                  MulDone;
  logic                  MulError;

  // environment side (control, memory model, multiplicator)
  modport master (
    output Start, Operation, BaseA, BaseB, BaseC,
    input  Busy, Done, Error,
    input  MemAddr, MemRead, MemWrite, MemDataOut,
    output MemDataIn,
    input  MulOperation, MulEnable, MulRowA, MulRowB,
    output MulNewRow, MulDone, MulError
  );

  // sequencer side
  modport slave (
    input  Start, Operation, BaseA, BaseB, BaseC,
    output Busy, Done, Error,
    output MemAddr, MemRead, MemWrite, MemDataOut,
    input  MemDataIn,
    output MulOperation, MulEnable, MulRowA, MulRowB,
    input  MulNewRow, MulDone, MulError
  );
endinterface

// File: rtl/row_multiply_sequencer.sv
// Row-by-row sequencer for the element-wise scalar multiplicator:
// reads row r of A and B, fires the multiplicator, writes the product
// row to C, with error/timeout handling and Busy/Done/Error reporting.
module row_multiply_sequencer #(
  parameter int ROWS    = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                     Clock,
  input  logic                     ClearAll,
  row_multiply_sequencer_if.slave  bus
);

  localparam int ROW_W = 4 * DATA_W;
  localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int T_W   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  logic [2:0]        state_q,  state_d;
  logic [R_W-1:0]    row_q,    row_d;
  logic [T_W-1:0]    tmo_q,    tmo_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic [ADDR_W-1:0] base_c_q, base_c_d;
  logic [ROW_W-1:0]  row_a_q,  row_a_d;
  logic [ROW_W-1:0]  row_b_q,  row_b_d;
  logic [ROW_W-1:0]  res_q,    res_d;
  logic              error_q,  error_d;

  logic [ADDR_W-1:0] row_off;
  logic              busy;

  assign row_off = ADDR_W'(row_q);

  // Next-state, row/timeout counters and data capture
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    tmo_d    = tmo_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    base_c_d = base_c_q;
    row_a_d  = row_a_q;
    row_b_d  = row_b_q;
    res_d    = res_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Operation == OP_MUL) begin
            base_a_d = bus.BaseA;
            base_b_d = bus.BaseB;
            base_c_d = bus.BaseC;
            row_d    = '0;
            error_d  = 1'b0;
            state_d  = S_RD_A;
          end else begin
            error_d  = 1'b1;
          end
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        row_a_d = bus.MemDataIn;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        row_b_d = bus.MemDataIn;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.MulError) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (bus.MulDone) begin
          res_d   = bus.MulNewRow;
          state_d = S_WR;
        end else if (tmo_q == T_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + T_W'(1);
        end
      end
      S_WR: begin
        if (row_q == R_W'(ROWS - 1)) begin
          state_d = S_FIN;
        end else begin
          row_d   = row_q + R_W'(1);
          state_d = S_RD_A;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    busy = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_EXEC) ||
           (state_q == S_WAIT) || (state_q == S_WR);
    bus.Busy         = busy;
    bus.Done         = (state_q == S_FIN);
    bus.Error        = error_q;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemAddr      = '0;
    bus.MemDataOut   = res_q;
    bus.MulOperation = busy ? OP_MUL : 3'b000;
    bus.MulEnable    = (state_q == S_EXEC);
    bus.MulRowA      = row_a_q;
    // B data is only arriving during EXEC, the same cycle the enable fires,
    // so the multiplicator sees it straight from memory in that cycle.
    bus.MulRowB      = (state_q == S_EXEC) ? bus.MemDataIn : row_b_q;
    case (state_q)
      S_RD_A: begin
        bus.MemRead = 1'b1;
        bus.MemAddr = base_a_q + row_off;
      end
      S_RD_B: begin
        bus.MemRead = 1'b1;
        bus.MemAddr = base_b_q + row_off;
      end
      S_WR: begin
        bus.MemWrite = 1'b1;
        bus.MemAddr  = base_c_q + row_off;
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      tmo_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      row_a_q  <= '0;
      row_b_q  <= '0;
      res_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      tmo_q    <= tmo_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      row_a_q  <= row_a_d;
      row_b_q  <= row_b_d;
      res_q    <= res_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_row_multiply_sequencer.sv
// Directed self-checking bench for row_multiply_sequencer with a memory
// model, a behavioural multiplicator and a write scoreboard.
module tb_row_multiply_sequencer;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int ROWS    = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [15:0]  a;
    logic [127:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  logic [127:0] mem [int unsigned];
  int mul_mode   = 0;   // 0 ideal, 1 MulError on third enable, 2 never done
  int enable_cnt = 0;

  row_multiply_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  row_multiply_sequencer #(
    .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(clk),
    .ClearAll(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {e3[31:0], e2[31:0], e1[31:0], e0[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory (one-cycle read latency) and multiplicator models
  initial begin : env_model
    logic        rd, en;
    logic [15:0] ad;
    logic [127:0] ra, rb, p;
    bus.MemDataIn = '0;
    bus.MulNewRow = '0;
    bus.MulDone   = 1'b0;
    bus.MulError  = 1'b0;
    forever begin
      @(negedge clk);
      rd = bus.MemRead;
      ad = bus.MemAddr;
      en = bus.MulEnable;
      ra = bus.MulRowA;
      rb = bus.MulRowB;
      @(posedge clk);
      #1;
      if (rd === 1'b1) bus.MemDataIn = mem.exists(ad) ? mem[ad] : '0;
      bus.MulDone  = 1'b0;
      bus.MulError = 1'b0;
      if (en === 1'b1) begin
        if (mul_mode == 1 && enable_cnt == 2) begin
          bus.MulError = 1'b1;
        end else if (mul_mode != 2) begin
          for (int k = 0; k < 4; k++) p[k*32 +: 32] = ra[k*32 +: 32] * rb[k*32 +: 32];
          bus.MulNewRow = p;
          bus.MulDone   = 1'b1;
        end
        enable_cnt++;
      end
    end
  end

  // Write scoreboard and strobe exclusivity monitor
  initial begin : wr_monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.MemRead === 1'b1 || bus.MemWrite === 1'b1)
        chk("rd_wr_exclusive", bus.MemRead & bus.MemWrite, 1'b0);
      if (bus.MemWrite === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                 bus.MemAddr, bus.MemDataOut);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.MemAddr, e.a);
          chk("wr_data", bus.MemDataOut, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic load_rows(input logic [15:0] ba, input logic [15:0] bb);
    for (int r = 0; r < ROWS; r++) begin
      mem[16'(ba + r)] = pack4(1 + r, 2 + r, 3 + r, 4 + r);
      mem[16'(bb + r)] = pack4(2, 2, 2, 2);
    end
  endtask

  task automatic push_exp(input logic [15:0] bc, input int nrows);
    for (int r = 0; r < nrows; r++)
      exp_q.push_back('{a: 16'(bc + r), d: pack4(2 * (1 + r), 2 * (2 + r), 2 * (3 + r), 2 * (4 + r))});
  endtask

  // Returns at the negedge of cycle 1 after the accept edge; bases are
  // scrambled afterwards so only the captured copies can be used.
  task automatic drive_start(input logic [2:0] op, input logic [15:0] ba,
                             input logic [15:0] bb, input logic [15:0] bc);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Operation = op;
    bus.BaseA = ba;
    bus.BaseB = bb;
    bus.BaseC = bc;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Operation = 3'b000;
    bus.BaseA = 16'h5A5A;
    bus.BaseB = 16'hA5A5;
    bus.BaseC = 16'h3C3C;
  endtask

  task automatic run_to_end(output int n, output bit saw_done);
    n = 1;
    saw_done = 1'b0;
    while (n <= 300) begin
      if (bus.Done === 1'b1) begin
        saw_done = 1'b1;
        break;
      end
      if (bus.Busy !== 1'b1) break;
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n <= 300) else begin
      errors++;
      $error("FAIL run_budget: observed %0d cycles expected completion within 300", n);
    end
  endtask

  initial begin : main
    int n;
    bit saw_done;
    bit found;
    bus.Start = 1'b0;
    bus.Operation = 3'b000;
    bus.BaseA = '0;
    bus.BaseB = '0;
    bus.BaseC = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy",   bus.Busy, 1'b0);
    chk("rst_done",   bus.Done, 1'b0);
    chk("rst_error",  bus.Error, 1'b0);
    chk("rst_memrd",  bus.MemRead, 1'b0);
    chk("rst_memwr",  bus.MemWrite, 1'b0);
    chk("rst_addr",   bus.MemAddr, 16'h0);
    chk("rst_dout",   bus.MemDataOut, 128'h0);
    chk("rst_rowa",   bus.MulRowA, 128'h0);
    chk("rst_rowb",   bus.MulRowB, 128'h0);
    chk("rst_mulen",  bus.MulEnable, 1'b0);
    chk("rst_mulop",  bus.MulOperation, 3'b000);
    rst = 1'b0;

    // 1: four ideal rows
    mul_mode = 0;
    load_rows(16'h0000, 16'h0004);
    push_exp(16'h0008, 4);
    drive_start(3'b100, 16'h0000, 16'h0004, 16'h0008);
    chk("t1_busy_c1",  bus.Busy, 1'b1);
    chk("t1_mulop_c1", bus.MulOperation, 3'b100);
    chk("t1_memrd_c1", bus.MemRead, 1'b1);
    chk("t1_addr_c1",  bus.MemAddr, 16'h0000);
    run_to_end(n, saw_done);
    chk("t1_done",       saw_done, 1'b1);
    chk("t1_done_cycle", n, 21);
    chk("t1_done_busy",  bus.Busy, 1'b0);
    chk("t1_error",      bus.Error, 1'b0);
    @(negedge clk);
    chk("t1_done_pulse", bus.Done, 1'b0);
    chk("t1_mulop_idle", bus.MulOperation, 3'b000);
    chk("t1_rowa_hold",  bus.MulRowA, pack4(4, 5, 6, 7));
    chk("t1_rowb_hold",  bus.MulRowB, pack4(2, 2, 2, 2));
    chk("t1_sb_empty",   exp_q.size(), 0);

    // 2: invalid opcode, then valid start clears Error
    drive_start(3'b010, 16'h0000, 16'h0004, 16'h0008);
    chk("t2_error",  bus.Error, 1'b1);
    chk("t2_busy",   bus.Busy, 1'b0);
    chk("t2_done",   bus.Done, 1'b0);
    chk("t2_memrd",  bus.MemRead, 1'b0);
    chk("t2_memwr",  bus.MemWrite, 1'b0);
    repeat (3) @(negedge clk);
    chk("t2_idle_memrd", bus.MemRead, 1'b0);
    chk("t2_error_held", bus.Error, 1'b1);
    push_exp(16'h0014, 4);
    drive_start(3'b100, 16'h0000, 16'h0004, 16'h0014);
    chk("t2_error_clr", bus.Error, 1'b0);
    run_to_end(n, saw_done);
    chk("t2_done",       saw_done, 1'b1);
    chk("t2_done_cycle", n, 21);
    @(negedge clk);
    chk("t2_sb_empty",   exp_q.size(), 0);

    // 3: MulError during row 2
    mul_mode = 1;
    enable_cnt = 0;
    push_exp(16'h0008, 2);
    drive_start(3'b100, 16'h0000, 16'h0004, 16'h0008);
    run_to_end(n, saw_done);
    chk("t3_no_done",   saw_done, 1'b0);
    chk("t3_err_cycle", n, 15);
    chk("t3_error",     bus.Error, 1'b1);
    repeat (3) @(negedge clk);
    chk("t3_sticky",    bus.Error, 1'b1);
    chk("t3_idle_done", bus.Done, 1'b0);
    chk("t3_sb_empty",  exp_q.size(), 0);

    // 4: timeout with MulDone never asserted
    mul_mode = 2;
    drive_start(3'b100, 16'h0000, 16'h0004, 16'h0008);
    run_to_end(n, saw_done);
    chk("t4_no_done",   saw_done, 1'b0);
    chk("t4_err_cycle", n, 4 + TIMEOUT);
    chk("t4_error",     bus.Error, 1'b1);
    @(negedge clk);

    // 5: C address wraps
    mul_mode = 0;
    push_exp(16'hFFFE, 4);
    drive_start(3'b100, 16'h0000, 16'h0004, 16'hFFFE);
    chk("t5_error_clr", bus.Error, 1'b0);
    run_to_end(n, saw_done);
    chk("t5_done",       saw_done, 1'b1);
    chk("t5_done_cycle", n, 21);
    @(negedge clk);
    chk("t5_sb_empty",   exp_q.size(), 0);

    // 6: reset in WR of row 1, then full restart
    push_exp(16'h0008, 4);
    drive_start(3'b100, 16'h0000, 16'h0004, 16'h0008);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.MemWrite === 1'b1 && bus.MemAddr === 16'h0009) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_found_wr1", found, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_memwr", bus.MemWrite, 1'b0);
    chk("t6_memrd", bus.MemRead, 1'b0);
    chk("t6_busy",  bus.Busy, 1'b0);
    chk("t6_outstanding", exp_q.size(), 2);
    exp_q.delete();
    rst = 1'b0;
    push_exp(16'h0008, 4);
    drive_start(3'b100, 16'h0000, 16'h0004, 16'h0008);
    run_to_end(n, saw_done);
    chk("t6_done",       saw_done, 1'b1);
    chk("t6_done_cycle", n, 21);
    @(negedge clk);
    chk("t6_sb_empty",   exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
